demux12_deser: RTL and testbench

DEMUX12_DESER -- requirements
Module: demux12_deser

---
 rtl/demux12_deser_pkg.sv | 10 +
 rtl/demux12_deser_if.sv | 28 ++
 rtl/demux12_deser_chan.sv | 63 ++++++
 rtl/demux12_deser.sv | 43 ++++
 tb/tb_demux12_deser.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/demux12_deser_pkg.sv
// Shared constants for the two-channel serial demultiplexer/deserializer.
// Channel encodings match the sel input polarity.
package demux12_pkg;

    localparam int W_DEFAULT = 8;

    localparam logic CH_A = 1'b1;
    localparam logic CH_B = 1'b0;

endpackage

// File: rtl/demux12_deser_if.sv
// Serial input bus plus the two deserialized word outputs with ready/valid.
// The slave side is the deserializer; the master side feeds bits and consumes words.
interface demux12_deser_if #(parameter int W = 8);

    logic         din;
    logic         sel;
    logic         din_valid;
    logic         clr;
    logic [W-1:0] a_data;
    logic         a_valid;
    logic         a_ready;
    logic         a_ovf;
    logic [W-1:0] b_data;
    logic         b_valid;
    logic         b_ready;
    logic         b_ovf;

    modport master (
        output din, sel, din_valid, clr, a_ready, b_ready,
        input  a_data, a_valid, a_ovf, b_data, b_valid, b_ovf
    );

    modport slave (
        input  din, sel, din_valid, clr, a_ready, b_ready,
        output a_data, a_valid, a_ovf, b_data, b_valid, b_ovf
    );

endinterface

// File: rtl/demux12_deser_chan.sv
// One deserializer channel: MSB-first shift register, bit counter, output
// register with ready/valid handshake and a sticky overflow flag.
module deser_chan #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         bit_valid,
    input  logic         bit_in,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         ovf
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic [W-1:0]  word_next;
    logic          take_bit;
    logic          complete;
    logic          can_load;
    logic          load;

    assign take_bit  = bit_valid && !clr;
    assign word_next = {shreg[W-2:0], bit_in};
    assign complete  = take_bit && (cnt == LAST);
    // A full output register can still be refilled when it is consumed this cycle.
    assign can_load  = !valid || ready;
    assign load      = complete && can_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
            data  <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (clr) begin
                shreg <= '0;
                cnt   <= '0;
                ovf   <= 1'b0;
            end else if (take_bit) begin
                shreg <= word_next;
                cnt   <= complete ? '0 : cnt + 1'b1;
                if (complete && !can_load)
                    ovf <= 1'b1;
            end

            if (load) begin
                data  <= word_next;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux12_deser.sv
// Two-channel serial demultiplexer: sel steers each qualified din bit to
// channel A or B, each of which assembles W-bit words independently.
module demux12_deser
    import demux12_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    demux12_deser_if.slave   bus
);

    logic a_bit_valid;
    logic b_bit_valid;

    assign a_bit_valid = bus.din_valid && (bus.sel == CH_A);
    assign b_bit_valid = bus.din_valid && (bus.sel == CH_B);

    deser_chan #(.W(W)) u_chan_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (bus.clr),
        .bit_valid (a_bit_valid),
        .bit_in    (bus.din),
        .ready     (bus.a_ready),
        .data      (bus.a_data),
        .valid     (bus.a_valid),
        .ovf       (bus.a_ovf)
    );

    deser_chan #(.W(W)) u_chan_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (bus.clr),
        .bit_valid (b_bit_valid),
        .bit_in    (bus.din),
        .ready     (bus.b_ready),
        .data      (bus.b_data),
        .valid     (bus.b_valid),
        .ovf       (bus.b_ovf)
    );

endmodule

// File: tb/tb_demux12_deser.sv
// Directed and random checks of demux12_deser against a word-level model
// that tracks each channel as a partial integer value plus a bit count.
module tb_demux12_deser;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    demux12_deser_if #(.W(W)) bus ();

    demux12_deser #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // index 0 = channel A (sel=1), 1 = channel B (sel=0)
    int         m_cnt   [2];
    int         m_part  [2];
    logic [7:0] m_data  [2];
    logic       m_valid [2];
    logic       m_ovf   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic d, input logic s, input logic dv,
                                input logic c, input logic ar, input logic br,
                                input logic rs);
        for (int ch = 0; ch < 2; ch++) begin
            logic rdy;
            logic routed;
            logic loaded;
            int   new_word;
            rdy      = (ch == 0) ? ar : br;
            routed   = dv && (s == (ch == 0));
            loaded   = 1'b0;
            new_word = 0;
            if (!rs) begin
                m_cnt[ch]   = 0;
                m_part[ch]  = 0;
                m_data[ch]  = '0;
                m_valid[ch] = 1'b0;
                m_ovf[ch]   = 1'b0;
            end else begin
                if (c) begin
                    m_cnt[ch]  = 0;
                    m_part[ch] = 0;
                    m_ovf[ch]  = 1'b0;
                end else if (routed) begin
                    m_part[ch] = (m_part[ch] * 2 + int'(d)) % (1 << W);
                    m_cnt[ch]++;
                    if (m_cnt[ch] == W) begin
                        m_cnt[ch] = 0;
                        if (!m_valid[ch] || rdy) begin
                            loaded   = 1'b1;
                            new_word = m_part[ch];
                        end else begin
                            m_ovf[ch] = 1'b1;
                        end
                        m_part[ch] = 0;
                    end
                end
                if (loaded) begin
                    m_data[ch]  = 8'(new_word);
                    m_valid[ch] = 1'b1;
                end else if (m_valid[ch] && rdy) begin
                    m_valid[ch] = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic d, input logic s, input logic dv,
                        input logic c, input logic ar, input logic br,
                        input logic rs);
        bus.din       = d;
        bus.sel       = s;
        bus.din_valid = dv;
        bus.clr       = c;
        bus.a_ready   = ar;
        bus.b_ready   = br;
        rst_n         = rs;
        model_update(d, s, dv, c, ar, br, rs);
        @(posedge clk);
        #1;
        chk("model_a_data",  32'(bus.a_data),  32'(m_data[0]));
        chk("model_a_valid", 32'(bus.a_valid), 32'(m_valid[0]));
        chk("model_a_ovf",   32'(bus.a_ovf),   32'(m_ovf[0]));
        chk("model_b_data",  32'(bus.b_data),  32'(m_data[1]));
        chk("model_b_valid", 32'(bus.b_valid), 32'(m_valid[1]));
        chk("model_b_ovf",   32'(bus.b_ovf),   32'(m_ovf[1]));
    endtask

    task automatic send_word(input logic s, input logic [7:0] w,
                             input logic ar, input logic br);
        for (int i = W - 1; i >= 0; i--)
            step(w[i], s, 1'b1, 1'b0, ar, br, 1'b1);
    endtask

    initial begin
        logic [7:0] wa;
        logic [7:0] wb;

        for (int ch = 0; ch < 2; ch++) begin
            m_cnt[ch] = 0; m_part[ch] = 0; m_data[ch] = '0;
            m_valid[ch] = 1'b0; m_ovf[ch] = 1'b0;
        end

        // reset with everything else active: reset must win
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_a_valid", 32'(bus.a_valid), 32'd0);
        chk("rst_a_data",  32'(bus.a_data),  32'd0);
        chk("rst_b_ovf",   32'(bus.b_ovf),   32'd0);

        // single A word A6
        send_word(1'b1, 8'hA6, 1'b0, 1'b0);
        chk("a6_valid",   32'(bus.a_valid), 32'd1);
        chk("a6_data",    32'(bus.a_data),  32'hA6);
        chk("a6_b_valid", 32'(bus.b_valid), 32'd0);

        // interleaved per bit: A F0, B 3C; first cycle also consumes A6
        wa = 8'hF0;
        wb = 8'h3C;
        for (int i = W - 1; i >= 0; i--) begin
            step(wa[i], 1'b1, 1'b1, 1'b0, (i == W - 1), 1'b0, 1'b1);
            step(wb[i], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("il_a_data",  32'(bus.a_data),  32'hF0);
        chk("il_b_data",  32'(bus.b_data),  32'h3C);
        chk("il_a_valid", 32'(bus.a_valid), 32'd1);
        chk("il_b_valid", 32'(bus.b_valid), 32'd1);
        chk("il_a_ovf",   32'(bus.a_ovf),   32'd0);
        chk("il_b_ovf",   32'(bus.b_ovf),   32'd0);

        // overflow: drain, then two A words with no consumer
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send_word(1'b1, 8'h11, 1'b0, 1'b0);
        send_word(1'b1, 8'h22, 1'b0, 1'b0);
        chk("ovf_a_data", 32'(bus.a_data), 32'h11);
        chk("ovf_a_ovf",  32'(bus.a_ovf),  32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("ovf_consumed", 32'(bus.a_valid), 32'd0);
        chk("ovf_sticky",   32'(bus.a_ovf),   32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(bus.a_ovf), 32'd0);

        // refill: 55 then AA, consumer accepts on the AA-completing edge
        send_word(1'b1, 8'h55, 1'b0, 1'b0);
        chk("rf_first", 32'(bus.a_data), 32'h55);
        wa = 8'hAA;
        for (int i = W - 1; i >= 0; i--)
            step(wa[i], 1'b1, 1'b1, 1'b0, (i == 0), 1'b0, 1'b1);
        chk("rf_valid", 32'(bus.a_valid), 32'd1);
        chk("rf_data",  32'(bus.a_data),  32'hAA);
        chk("rf_ovf",   32'(bus.a_ovf),   32'd0);

        // partial word discarded by reset, then by clr
        wa = 8'hFF;
        for (int i = 0; i < 4; i++)
            step(wa[i], 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(1'b1, 8'hC3, 1'b0, 1'b0);
        chk("prst_data", 32'(bus.a_data), 32'hC3);
        for (int i = 0; i < 4; i++)
            step(wa[i], 1'b1, 1'b1, 1'b0, (i == 0), 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send_word(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("pclr_data", 32'(bus.a_data), 32'h3C);

        // idle with toggling din/sel must not advance anything
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++)
            step(1'(i), 1'(i >> 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("idle_a_valid", 32'(bus.a_valid), 32'd0);
        chk("idle_b_valid", 32'(bus.b_valid), 32'd0);
        wb = 8'h81;
        for (int i = W - 1; i >= 1; i--)
            step(wb[i], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("idle_b_partial", 32'(bus.b_valid), 32'd0);
        step(wb[0], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("idle_b_word", 32'(bus.b_data), 32'h81);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 60) == 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 200) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
